// File: rtl/ifu_fetch_resp.sv
// Memory-side fetch responder for the IFU: one single-beat read per pc, returning
// the selected 32-bit word with a one-cycle update pulse, including error/timeout paths.
//   state | meaning
//   IDLE  | waiting for fetch_en (and no stale beat to drain)
//   REQ   | arvalid up, waiting for arready
//   WAIT  | rready up, counting toward timeout
//   RESP  | update pulse, instr/fetch_err valid
module ifu_fetch_resp #(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc,
  input  logic        fetch_en,
  output logic [31:0] instr,
  output logic        update,
  output logic        fetch_err,
  output logic        busy,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [63:2] pc_q;
  logic [15:0] cnt;
  logic        drain_pend;
  logic        start;
  logic        misaligned;
  logic        timeout;

  assign start      = fetch_en && !drain_pend;
  assign misaligned = (pc[1:0] != 2'b00);
  assign timeout    = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = misaligned ? RESP : REQ;
      REQ:  if (arready) state_nxt = WAIT;
      WAIT: if (rvalid || timeout) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arvalid = (state == REQ);
  // A timed-out beat may still arrive later; keep accepting it until it is drained.
  assign rready  = (state == WAIT) || drain_pend;
  assign update  = (state == RESP);
  assign busy    = (state != IDLE) || drain_pend;
  assign araddr  = {pc_q[63:3], 3'b000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pc_q       <= '0;
      cnt        <= '0;
      drain_pend <= 1'b0;
      instr      <= '0;
      fetch_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drain_pend && rvalid) drain_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc_q <= pc[63:2];
            if (misaligned) begin
              instr     <= ERR_INSTR;
              fetch_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (arready) cnt <= '0;
        end
        WAIT: begin
          if (rvalid) begin
            fetch_err <= (rresp != 2'b00);
            if (rresp != 2'b00) instr <= ERR_INSTR;
            else                instr <= pc_q[2] ? rdata[63:32] : rdata[31:0];
          end else if (timeout) begin
            fetch_err  <= 1'b1;
            instr      <= ERR_INSTR;
            drain_pend <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_resp.sv
// Randomized and directed bench for ifu_fetch_resp; expected results come from a
// transaction-level model of latency and word selection.
module tb_ifu_fetch_resp;
  localparam int          T    = 4;
  localparam logic [31:0] ERRI = 32'h0000_0013;

  logic        clk, rstn;
  logic [63:0] pc;
  logic        fetch_en;
  logic [31:0] instr;
  logic        update, fetch_err, busy;
  logic [63:0] araddr;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch_resp #(.TIMEOUT_CYC(T), .ERR_INSTR(ERRI)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .fetch_en(fetch_en),
    .instr(instr), .update(update), .fetch_err(fetch_err), .busy(busy),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One fetch: slave raises arready after ad REQ cycles, returns rvalid in WAIT
  // cycle rd (never, if rd >= T). Cycle 0 is the IDLE capture cycle.
  task automatic fetch_txn(input logic [63:0] pc_v, input logic [63:0] data,
                           input logic [1:0] resp, input int ad, input int rd,
                           input string tag);
    logic [31:0] exp_instr;
    logic        exp_err;
    int          exp_cyc;
    logic [63:0] exp_addr;
    int          ups;
    int          arv_seen;
    int          wc;
    bit          hs;
    bit          rsent;
    ups = 0; arv_seen = 0; wc = 0; hs = 0; rsent = 0;
    exp_addr = {pc_v[63:3], 3'b000};
    if (pc_v[1:0] != 2'b00) begin
      exp_err = 1'b1; exp_instr = ERRI; exp_cyc = 1;
    end else if (rd >= T) begin
      exp_err = 1'b1; exp_instr = ERRI; exp_cyc = 2 + ad + T;
    end else begin
      exp_err   = (resp != 2'b00);
      exp_instr = exp_err ? ERRI : (pc_v[2] ? data[63:32] : data[31:0]);
      exp_cyc   = 3 + ad + rd;
    end

    @(negedge clk);
    pc = pc_v; fetch_en = 1'b1; arready = 1'b0; rvalid = 1'b0;
    for (int e = 0; e < exp_cyc + 4; e++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      pc = {$urandom, $urandom};
      if (update) begin
        ups++;
        n_checks++;
        if (e + 1 != exp_cyc) begin
          n_fail++;
          $display("FAIL %s update_cycle: got %0d want %0d", tag, e + 1, exp_cyc);
        end
        n_checks++;
        if (instr !== exp_instr) begin
          n_fail++;
          $display("FAIL %s instr: got %h want %h", tag, instr, exp_instr);
        end
        n_checks++;
        if (fetch_err !== exp_err) begin
          n_fail++;
          $display("FAIL %s fetch_err: got %b want %b", tag, fetch_err, exp_err);
        end
      end
      if (arvalid) begin
        arv_seen++;
        n_checks++;
        if (araddr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s araddr: got %h want %h", tag, araddr, exp_addr);
        end
      end else if (arv_seen > 0 && !hs) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s arvalid_stable: got 0 want 1", tag);
      end
      rvalid = 1'b0;
      if (hs && !rsent && wc == rd) begin
        rvalid = 1'b1; rdata = data; rresp = resp; rsent = 1;
        n_checks++;
        if (rready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s rready_wait: got %b want 1", tag, rready);
        end
      end
      if (hs) wc++;
      if (!hs && arvalid && arv_seen > ad) begin
        arready = 1'b1; hs = 1;
      end else begin
        arready = 1'b0;
      end
    end
    rvalid = 1'b0; arready = 1'b0;
    n_checks++;
    if (ups != 1) begin
      n_fail++;
      $display("FAIL %s update_count: got %0d want 1", tag, ups);
    end
    n_checks++;
    if (arv_seen != ((pc_v[1:0] != 2'b00) ? 0 : ad + 1)) begin
      n_fail++;
      $display("FAIL %s arvalid_cycles: got %0d want %0d", tag, arv_seen,
               (pc_v[1:0] != 2'b00) ? 0 : ad + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({instr, update, fetch_err, busy, araddr, arvalid, rready} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs_zero: got instr=%h upd=%b err=%b busy=%b addr=%h arv=%b rr=%b want all 0",
               tag, instr, update, fetch_err, busy, araddr, arvalid, rready);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; fetch_en = 1'b0; pc = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_directed();
    fetch_txn(64'h8000_0000, 64'h00100073_00000513, 2'b00, 0, 0, "zw_lo");
    fetch_txn(64'h8000_0004, 64'h00100073_00000513, 2'b00, 0, 0, "zw_hi");
    fetch_txn(64'h8000_0000, 64'h00100073_00000513, 2'b00, 5, 0, "ar_stall");
    fetch_txn(64'h8000_0008, 64'h00100073_00000513, 2'b10, 0, 0, "rresp_err");
    fetch_txn(64'h8000_0002, 64'h00100073_00000513, 2'b00, 0, 0, "misaligned");
    fetch_txn(64'h8000_0010, 64'h11111111_22222222, 2'b00, 1, T - 1, "late_rvalid");
  endtask

  task automatic test_random();
    logic [63:0] p;
    logic [1:0]  r;
    for (int i = 0; i < 24; i++) begin
      p = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) p[1:0] = 2'b00;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch_txn(p, {$urandom, $urandom}, r, $urandom_range(0, 4),
                $urandom_range(0, T - 1), "random");
    end
  endtask

  task automatic test_timeout_drain();
    fetch_txn(64'h0000_1000, 64'h0, 2'b00, 0, T + 6, "timeout");
    @(negedge clk);
    pc = 64'h0000_2000; fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || arvalid !== 1'b0 || rready !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_hold: got busy=%b arvalid=%b rready=%b want 1 0 1",
                 busy, arvalid, rready);
      end
    end
    fetch_en = 1'b0;
    rvalid = 1'b1; rdata = 64'hDEADBEEF_CAFEF00D; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_clear busy: got %b want 0", busy);
    end
    n_checks++;
    if (instr !== ERRI || update !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_discard: got instr=%h update=%b want %h 0", instr, update, ERRI);
    end
    fetch_txn(64'h0000_2004, 64'h0A0B0C0D_01020304, 2'b00, 0, 0, "after_drain");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    pc = 64'h0000_3000; fetch_en = 1'b1; arready = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("reset_mid_wait");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (update !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got update=%b busy=%b arvalid=%b want 0 0 0",
                 update, busy, arvalid);
      end
    end
    fetch_txn(64'h0000_3004, 64'h55667788_99AABBCC, 2'b00, 2, 1, "restart");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout_drain();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_resp.md
Name: ifu_fetch_resp

Overview:
Instruction-fetch responder on the memory side of the pipeline IFU interface. It samples the IFU's current pc and issues a single-beat read on a valid/ready read channel. It returns the selected 32-bit instruction word with a one-cycle update pulse, which is exactly what the IFU consumes to advance pc and its IF/ID register. It also handles bus errors, misaligned pc and slave timeouts, so the IFU never stalls forever.

Parameters:
TIMEOUT_CYC, 255, cycles waited in WAIT for rvalid before forcing an error response; range 1..65535.
ERR_INSTR, 32'h0000_0013, instr value driven with fetch_err (nop).

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
pc  input  64  current fetch pc from IFU
fetch_en  input  1  permits starting a new fetch from IDLE
instr  output  32  fetched instruction, valid while update=1
update  output  1  one-cycle pulse: instr/fetch_err valid, IFU advances
fetch_err  output  1  qualifies update: bus error, misaligned pc or timeout
busy  output  1  high whenever state != IDLE or drain_pend=1
araddr  output  64  read address, {pc_q[63:3],3'b000}
arvalid  output  1  address valid
arready  input  1  address accepted
rdata  input  64  read data
rresp  input  2  read response; nonzero = error
rvalid  input  1  read data valid
rready  output  1  read data accept

Behaviour:
- Reset (async, rstn=0): state=IDLE; instr=0, update=0, fetch_err=0, arvalid=0, rready=0, araddr=0, busy=0, drain_pend=0, timeout counter=0. Effective immediately, including mid-REQ/WAIT/RESP; no response is produced for an aborted fetch.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if fetch_en=1 and drain_pend=0, capture pc into pc_q.
  - pc[1:0]!=0: go to RESP with fetch_err=1, instr=ERR_INSTR; no bus access.
  - Otherwise: go to REQ.
  - If fetch_en=0 or drain_pend=1: stay in IDLE.
- REQ: arvalid=1, araddr held stable. On arvalid&arready go to WAIT. No timeout in REQ.
- WAIT: rready=1; counter increments each cycle.
  - rvalid=1: latch instr = pc_q[2] ? rdata[63:32] : rdata[31:0], fetch_err = (rresp!=0), then go to RESP. On rresp error, instr=ERR_INSTR.
  - Counter reaching TIMEOUT_CYC-1 without rvalid: fetch_err=1, instr=ERR_INSTR, set drain_pend=1, go to RESP.
- RESP: update=1 for exactly one cycle, then IDLE. instr/fetch_err hold their values until the next RESP; they are only meaningful while update=1.
- drain_pend: while set, rready=1 in every state. The first rvalid seen is discarded and clears drain_pend. A new fetch never starts while drain_pend=1.
- Latency with a zero-wait slave (arready=1, rvalid the cycle after the handshake): IDLE capture in cycle 0, REQ in cycle 1, WAIT in cycle 2, update=1 in cycle 3. The next IDLE (cycle 4) samples the pc the IFU updated at the end of cycle 3. Throughput is 1 instruction per 4 cycles.
- pc changes while not in IDLE are ignored; only pc_q is used.
- rvalid arriving outside WAIT with drain_pend=0 is a protocol violation; it is ignored (rready=0).
- The counter resets to 0 on entry to WAIT.

Test Plan:
- Zero-wait slave, pc=0x80000000, rdata=0x00100073_00000513, rresp=0 -> araddr=0x80000000; update pulses in cycle 3 with instr=0x00000513, fetch_err=0; with pc=0x80000004 the same data gives instr=0x00100073.
- arready low for 5 cycles in REQ -> arvalid and araddr stay stable; update arrives 5 cycles later than the zero-wait case; exactly one update pulse.
- rresp=2'b10 on the returned beat -> update=1, fetch_err=1, instr=0x00000013.
- pc=0x80000002 -> no arvalid ever asserted; update=1 in cycle 1 with fetch_err=1, instr=0x13.
- TIMEOUT_CYC=4 with rvalid withheld -> update with fetch_err=1 after 4 WAIT cycles; busy stays 1 and no new arvalid until a late rvalid is drained; the drained data never appears on instr.
- rstn asserted mid-WAIT, then released -> all outputs 0 asynchronously; no update pulse; fetch_en=0 keeps the block in IDLE, and the fetch restarts in IDLE once fetch_en=1.
